// File: rtl/booth_mult_arbiter_if.sv
// Requester and multiplier handshake bundle for booth_mult_arbiter.
// Requesters hold req[i] high with stable operands until their resp_valid[i]
// pulse. The multiplier gets a one-cycle mul_start and answers with mul_done
// plus mul_product. A response is accepted only on the resp_valid pulse, and
// resp_err qualifies it. There is no ready/back-pressure on the response side.
interface booth_mult_arbiter_if #(
    parameter int N    = 16,
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] op_a;
    logic [NREQ*N-1:0] op_b;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   resp_valid;
    logic              resp_err;
    logic [2*N-1:0]    result;
    logic              busy;
    logic              mul_start;
    logic [N-1:0]      mul_a;
    logic [N-1:0]      mul_b;
    logic              mul_done;
    logic [2*N-1:0]    mul_product;

    // Arbiter side
    modport slave (
        input  req, op_a, op_b, mul_done, mul_product,
        output grant, resp_valid, resp_err, result, busy, mul_start, mul_a, mul_b
    );

    // Environment side: requesters plus the multiplier
    modport master (
        output req, op_a, op_b, mul_done, mul_product,
        input  grant, resp_valid, resp_err, result, busy, mul_start, mul_a, mul_b
    );
endinterface

// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter and sequencer that shares one Booth multiplier among
// NREQ requesters. It latches the winner's operands, pulses mul_start, and
// waits for mul_done under a timeout guard. It then returns the product, or a
// timeout error, to the winning requester. All outputs are registered.
module booth_mult_arbiter #(
    parameter int N       = 16,
    parameter int NREQ    = 4,
    parameter int IDXW    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                clock,
    input  logic                reset,
    booth_mult_arbiter_if.slave bus,
    output logic [1:0]          dbg_state_o
);
    localparam int CNTW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e          state_q;
    logic [IDXW-1:0] ptr_q;
    logic [IDXW-1:0] win_q;
    logic [CNTW-1:0] cnt_q;
    logic [N-1:0]    mul_a_q;
    logic [N-1:0]    mul_b_q;
    logic [2*N-1:0]  result_q;
    logic [NREQ-1:0] grant_q;
    logic [NREQ-1:0] resp_valid_q;
    logic            resp_err_q;
    logic            busy_q;
    logic            mul_start_q;

    // Next winner and its operands, valid whenever any req bit is set
    logic [IDXW-1:0] win_d;
    logic [N-1:0]    a_d;
    logic [N-1:0]    b_d;
    logic [N-1:0]    a_arr [NREQ];
    logic [N-1:0]    b_arr [NREQ];
    logic            found_w;
    int              scan_idx;
    logic [IDXW-1:0] sidx;

    // Split the packed operand buses into per-requester slices
    always_comb begin
        for (int j = 0; j < NREQ; j++) begin
            a_arr[j] = bus.op_a[j*N +: N];
            b_arr[j] = bus.op_b[j*N +: N];
        end
    end

    // Scan ptr, ptr+1, ... (wrapping) and take the first asserted request
    always_comb begin
        win_d    = '0;
        a_d      = '0;
        b_d      = '0;
        found_w  = 1'b0;
        scan_idx = 0;
        sidx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = int'(ptr_q) + k;
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            sidx = IDXW'(scan_idx);
            if (!found_w && bus.req[sidx]) begin
                found_w = 1'b1;
                win_d   = sidx;
                a_d     = a_arr[sidx];
                b_d     = b_arr[sidx];
            end
        end
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            win_q        <= '0;
            cnt_q        <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            result_q     <= '0;
            grant_q      <= '0;
            resp_valid_q <= '0;
            resp_err_q   <= 1'b0;
            busy_q       <= 1'b0;
            mul_start_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (found_w) begin
                        win_q       <= win_d;
                        mul_a_q     <= a_d;
                        mul_b_q     <= b_d;
                        grant_q     <= NREQ'(1) << win_d;
                        mul_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    mul_start_q <= 1'b0;
                    cnt_q       <= CNTW'(TIMEOUT);
                    state_q     <= S_WAIT;
                end
                S_WAIT: begin
                    // A done arriving together with an expired counter still counts as success
                    if (bus.mul_done) begin
                        result_q     <= bus.mul_product;
                        resp_err_q   <= 1'b0;
                        resp_valid_q <= NREQ'(1) << win_q;
                        state_q      <= S_RESP;
                    end else if (cnt_q == '0) begin
                        result_q     <= '0;
                        resp_err_q   <= 1'b1;
                        resp_valid_q <= NREQ'(1) << win_q;
                        state_q      <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - CNTW'(1);
                    end
                end
                S_RESP: begin
                    resp_valid_q <= '0;
                    resp_err_q   <= 1'b0;
                    grant_q      <= '0;
                    busy_q       <= 1'b0;
                    // The requester just served drops to lowest priority
                    if (win_q == IDXW'(NREQ - 1)) begin
                        ptr_q <= '0;
                    end else begin
                        ptr_q <= win_q + IDXW'(1);
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.grant      = grant_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.result     = result_q;
    assign bus.busy       = busy_q;
    assign bus.mul_start  = mul_start_q;
    assign bus.mul_a      = mul_a_q;
    assign bus.mul_b      = mul_b_q;
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Bench for booth_mult_arbiter: a behavioural multiplier, a round-robin
// reference model, and a scoreboard of expected responses.
module tb_booth_mult_arbiter;
    localparam int N       = 16;
    localparam int NREQ    = 4;
    localparam int IDXW    = 2;
    localparam int TIMEOUT = 64;
    localparam int DLYW    = 8;
    localparam int EW      = 1 + IDXW + DLYW + 4*N;

    logic       clock;
    logic       reset;
    logic [1:0] dbg_state;

    booth_mult_arbiter_if #(.N(N), .NREQ(NREQ)) bus();

    booth_mult_arbiter #(.N(N), .NREQ(NREQ), .IDXW(IDXW), .TIMEOUT(TIMEOUT)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_resp = 0;
    int issue_cyc = 0;
    int m_ptr = 0;
    int lat = 1;
    bit never_done = 0;
    bit hold_done = 0;
    int mcnt = 0;
    logic prev_start = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;
    logic [2*N-1:0] last_result = '0;
    logic [NREQ-1:0] last_rv = '0;
    logic last_err = 0;

    // ---------------- clock / reset ----------------
    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not reach its end, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2*N-1:0] smul(input logic [N-1:0] a, input logic [N-1:0] b);
        logic signed [2*N-1:0] p;
        p = $signed(a) * $signed(b);
        return p;
    endfunction

    // Round robin: first asserted requester at or after the pointer
    function automatic int pick(input logic [NREQ-1:0] m, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (m[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return 0;
    endfunction

    // ---------------- multiplier model ----------------
    always @(negedge clock) begin
        if (reset) begin
            mcnt = 0;
            if (!hold_done) begin
                bus.mul_done    = 0;
                bus.mul_product = '0;
            end
        end else if (hold_done) begin
            bus.mul_done    = 1;
            bus.mul_product = smul(bus.mul_a, bus.mul_b);
        end else begin
            bus.mul_done = 0;
            if (bus.mul_start) begin
                mcnt = lat;
            end else if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0 && !never_done) begin
                    bus.mul_done    = 1;
                    bus.mul_product = smul(bus.mul_a, bus.mul_b);
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clock) begin
        if (reset) begin
            prev_start = 0;
        end else begin
            if (bus.mul_start) begin
                check_val("start_pulse", 64'(prev_start), 64'd0);
                if (exp_q.size() == 0) begin
                    check_val("start_unexp", 64'(bus.mul_start), 64'd0);
                end else begin
                    mon_e = exp_q[0];
                    check_val("issue_grant", 64'(bus.grant), 64'(NREQ'(1) << mon_e[EW-2 -: IDXW]));
                    check_val("issue_mul_a", 64'(bus.mul_a), 64'(mon_e[4*N-1 -: N]));
                    check_val("issue_mul_b", 64'(bus.mul_b), 64'(mon_e[3*N-1 -: N]));
                    check_val("issue_busy", 64'(bus.busy), 64'd1);
                    issue_cyc = cyc;
                end
            end
            if (bus.resp_valid != '0) begin
                n_resp++;
                last_result = bus.result;
                last_rv     = bus.resp_valid;
                last_err    = bus.resp_err;
                if (exp_q.size() == 0) begin
                    check_val("resp_unexp", 64'(bus.resp_valid), 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_val("resp_valid", 64'(bus.resp_valid), 64'(NREQ'(1) << mon_e[EW-2 -: IDXW]));
                    check_val("resp_grant", 64'(bus.grant), 64'(bus.resp_valid));
                    check_val("resp_result", 64'(bus.result), 64'(mon_e[2*N-1:0]));
                    check_val("resp_err", 64'(bus.resp_err), 64'(mon_e[EW-1]));
                    check_val("resp_delay", 64'(cyc - issue_cyc), 64'(mon_e[4*N+DLYW-1 -: DLYW]));
                end
            end
            prev_start = bus.mul_start;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_op(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
        bus.op_a[i*N +: N] = a;
        bus.op_b[i*N +: N] = b;
    endtask

    // Predict the next served requester and its response, then queue it
    task automatic push_op(input logic [NREQ-1:0] mask);
        int idx;
        int edges;
        logic err;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [2*N-1:0] res;
        idx   = pick(mask, m_ptr);
        m_ptr = (idx + 1) % NREQ;
        a     = bus.op_a[idx*N +: N];
        b     = bus.op_b[idx*N +: N];
        // done is seen on WAIT edge number 'edges'; timeout strikes on edge TIMEOUT+1
        edges = hold_done ? 1 : lat;
        err   = (never_done && !hold_done) || (edges > TIMEOUT + 1);
        if (err) edges = TIMEOUT + 1;
        res = err ? '0 : smul(a, b);
        exp_q.push_back({err, IDXW'(idx), DLYW'(edges + 1), a, b, res});
    endtask

    task automatic run_ops(input logic [NREQ-1:0] mask, input int n);
        int target;
        for (int i = 0; i < n; i++) push_op(mask);
        target  = n_resp + n;
        bus.req = mask;
        for (int c = 0; c < n * (TIMEOUT + 10) && n_resp < target; c++) begin
            @(posedge clock);
            #1;
        end
        bus.req = '0;
        check_val("resp_count", 64'(n_resp), 64'(target));
        check_val("sb_empty", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic check_zero(input string pfx);
        check_val({pfx, "_grant"}, 64'(bus.grant), 64'd0);
        check_val({pfx, "_resp_valid"}, 64'(bus.resp_valid), 64'd0);
        check_val({pfx, "_resp_err"}, 64'(bus.resp_err), 64'd0);
        check_val({pfx, "_result"}, 64'(bus.result), 64'd0);
        check_val({pfx, "_busy"}, 64'(bus.busy), 64'd0);
        check_val({pfx, "_mul_start"}, 64'(bus.mul_start), 64'd0);
        check_val({pfx, "_mul_a"}, 64'(bus.mul_a), 64'd0);
        check_val({pfx, "_mul_b"}, 64'(bus.mul_b), 64'd0);
        check_val({pfx, "_state"}, 64'(dbg_state), 64'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int rsp_before;
        bit seen;
        logic [NREQ-1:0] mask;

        reset    = 1;
        bus.req  = '0;
        bus.op_a = '0;
        bus.op_b = '0;
        repeat (3) @(posedge clock);
        #1;
        check_zero("rst");
        @(negedge clock);
        reset = 0;
        m_ptr = 0;

        // Single request, 17-cycle multiplier
        set_op(0, 16'h1234, 16'hABCD);
        lat = 17;
        run_ops(4'b0001, 1);
        check_val("t1_result", 64'(last_result), 64'h0000_0000_FA03_4FA4);
        check_val("t1_rv", 64'(last_rv), 64'd1);

        // Contention: all four held, five operations
        set_op(0, 16'h0003, 16'hFFFE);
        set_op(1, 16'h7FFF, 16'h7FFF);
        set_op(2, 16'h8000, 16'h8000);
        set_op(3, 16'h8000, 16'h7FFF);
        lat = 3;
        run_ops(4'b1111, 5);

        // Pointer wrap: serve 2 (ptr=3), then 1001 serves 3 then 0, ptr back to 1
        set_op(2, 16'h0011, 16'h0022);
        run_ops(4'b0100, 1);
        run_ops(4'b1001, 2);
        check_val("wrap_last", 64'(last_rv), 64'd1);
        run_ops(4'b1111, 1);
        check_val("wrap_ptr1", 64'(last_rv), 64'd2);

        // Timeout, then a normal operation, then done coinciding with counter==0
        never_done = 1;
        run_ops(4'b0010, 1);
        check_val("to_err", 64'(last_err), 64'd1);
        check_val("to_result", 64'(last_result), 64'd0);
        never_done = 0;
        lat = 5;
        run_ops(4'b0010, 1);
        check_val("after_to_err", 64'(last_err), 64'd0);
        lat = TIMEOUT + 1;
        run_ops(4'b1000, 1);
        check_val("edge_done_err", 64'(last_err), 64'd0);

        // Reset in the middle of WAIT
        lat = 40;
        set_op(2, 16'h4321, 16'h0F0F);
        push_op(4'b0100);
        bus.req = 4'b0100;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge clock);
            #1;
            seen = bus.mul_start;
        end
        check_val("rst_issue_seen", 64'(seen), 64'd1);
        repeat (10) @(posedge clock);
        #3;
        reset = 1;
        #1;
        check_zero("midrst");
        bus.req = '0;
        exp_q.delete();
        m_ptr = 0;
        rsp_before = n_resp;
        repeat (3) @(negedge clock);
        reset = 0;
        repeat (5) @(posedge clock);
        #1;
        check_val("rst_no_resp", 64'(n_resp), 64'(rsp_before));
        lat = 2;
        run_ops(4'b1111, 1);
        check_val("rst_regrant", 64'(last_rv), 64'd1);

        // Stale done held through IDLE and ISSUE
        hold_done = 1;
        set_op(2, 16'hFFFF, 16'h0005);
        repeat (3) @(posedge clock);
        #1;
        run_ops(4'b0100, 1);
        hold_done = 0;
        check_val("stale_result", 64'(last_result), 64'h0000_0000_FFFF_FFFB);

        // Randomized rounds
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < NREQ; i++) set_op(i, N'($urandom()), N'($urandom()));
            mask = NREQ'($urandom_range(1, 15));
            lat  = $urandom_range(1, 20);
            run_ops(mask, $urandom_range(1, 4));
        end

        repeat (3) @(posedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/booth_mult_arbiter.md
Name: booth_mult_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one signed 16x16 Booth multiplier datapath/controller pair among NREQ requesters.
- Accepts per-requester multiply requests and latches the winner's operands.
- Issues a start pulse to the multiplier, waits for its done with a timeout guard, and returns the 32-bit product to the winning requester.
- Sits between the requesting units and the multiplier's start/done/product interface.

Parameters:
- N, 16: operand width; product width is 2*N.
- NREQ, 4: number of requesters.
- IDXW, 2: requester index width, ceil(log2(NREQ)).
- TIMEOUT, 64: max WAIT cycles before abort; must be greater than worst-case multiplier latency.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NREQ  request per requester; held high with stable operands until that requester's resp_valid.
- op_a  in  NREQ*N  multiplicand per requester; requester i occupies bits [i*N +: N].
- op_b  in  NREQ*N  multiplier per requester, same packing as op_a.
- grant  out  NREQ  one-hot; marks the requester being served.
- resp_valid  out  NREQ  one-hot, one-cycle pulse: result is valid for that requester.
- resp_err  out  1  qualifies resp_valid; high means timeout abort.
- result  out  2*N  product, valid while any resp_valid bit is high.
- busy  out  1  high when state is not IDLE.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_a  out  N  operand to the multiplier's M register; stable from ISSUE through WAIT.
- mul_b  out  N  operand to the multiplier's B register; stable from ISSUE through WAIT.
- mul_done  in  1  multiplier completion; sampled only in WAIT.
- mul_product  in  2*N  multiplier product; sampled on the edge where mul_done is seen in WAIT.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE; ptr=0; all outputs 0; operand, result and winner registers 0; timeout counter 0.
  - No response is issued for an aborted operation.
  - The multiplier is reset separately; the arbiter does not recover its state.
- All outputs are registered or decoded from registered state (Moore); there are no combinational paths from inputs to outputs.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req is nonzero at a rising edge, select the first asserted index scanning ptr, ptr+1, ... mod NREQ.
  - Latch winner index, op_a slice and op_b slice, then move to ISSUE.
  - If req is zero, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - mul_start=1; grant[winner]=1; mul_a and mul_b driven from the latched operands.
  - Load timeout counter with TIMEOUT, then move to WAIT.
- WAIT:
  - grant[winner]=1; mul_start=0; counter decrements each cycle.
  - If mul_done=1: capture mul_product into result, set err=0, move to RESP.
  - Else if counter==0: set result=0, err=1, move to RESP.
  - If mul_done and counter==0 occur in the same cycle, done wins (err=0).
- RESP (exactly 1 cycle):
  - resp_valid[winner]=1; resp_err=err; grant[winner] stays 1.
  - Next state is IDLE; ptr <= (winner+1) mod NREQ.
- Latency: req seen at edge k gives ISSUE in cycle k+1. mul_done seen at edge m gives resp_valid in cycle m+1. Minimum request-to-response is 4 cycles (done seen on the first WAIT edge).
- Signal sampling and don't-cares:
  - mul_done is ignored outside WAIT, so a done held over from a previous operation is not seen before ISSUE completes.
  - req changes outside IDLE are ignored; a requester dropping req mid-operation still receives its response.
  - A requester still asserting req after its response is re-arbitrated at lowest priority.
- Fairness:
  - A requester holding req waits at most NREQ-1 other operations.
  - Simultaneous requests are resolved purely by ptr.
- Arithmetic: the arbiter does no arithmetic on operands or products; they pass through unmodified. The product is signed two's complement as produced by the multiplier.
- Widths: operand slices use index*N offsets; ptr wraps from NREQ-1 to 0 using an explicit compare, not natural overflow.

Test Plan:
- Single request: req=4'b0001, op_a[0]=16'h1234, op_b[0]=16'hABCD, multiplier model returns done after 17 cycles -> grant=0001, one mul_start pulse with mul_a=1234, mul_b=ABCD; resp_valid=0001 with result=32'hFA034FA4, resp_err=0; ptr=1.
- Contention/fairness: req=4'b1111 held, distinct operands -> serve order 0,1,2,3,0; exactly one grant bit per operation; each result matches its requester's operands.
- Pointer wrap: ptr=3 after serving requester 2, req=4'b1001 -> requester 3 served first, then 0; ptr returns to 1.
- Timeout: model never asserts done, TIMEOUT=64 -> resp_valid pulses 65 WAIT cycles after ISSUE with resp_err=1, result=0; next request is served normally. Also done coinciding with counter==0 -> resp_err=0.
- Reset mid-WAIT: assert reset asynchronously between edges -> all outputs 0 immediately, state IDLE, no resp_valid; the next request is granted from requester 0.
- Stale done: mul_done held high through IDLE and ISSUE -> ignored until WAIT; result captured at the first WAIT edge, giving the minimum 4-cycle latency.
